// File: rtl/calc_seq_alu.sv
// Sequential W-bit calculator: one-cycle logic/add/sub, W-cycle shift-add multiply and restoring divide.
// Optional remainder opcode (111) enabled by defining CALC_REM_EN.
module calc_seq_alu #(
   parameter int unsigned W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           neg,
   output logic           err
);
   localparam int unsigned CNT_W = $clog2(W) + 1;
   localparam int unsigned RW    = 2 * W;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_REM = 3'b111;

   typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic [RW-1:0]    work_q, work_d;
   logic             busy_q, busy_d, done_q, done_d, neg_q, neg_d, err_q, err_d;
   logic [RW-1:0]    result_q, result_d;

   logic             iter_op_c;
   logic [W:0]       mul_sum_c, div_sh_c, div_diff_c;
   logic             div_ge_c;

   // Opcodes that use the iterative datapath
   always_comb begin
`ifdef CALC_REM_EN
      iter_op_c = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
`else
      iter_op_c = (op == OP_MUL) || (op == OP_DIV);
`endif
   end

   // One multiply step (upper half accumulates, product shifts right) and one restoring divide step
   // (upper half is the partial remainder, lower half shifts dividend out and quotient in).
   always_comb begin
      mul_sum_c  = {1'b0, work_q[RW-1:W]} + (work_q[0] ? {1'b0, a_q} : (W+1)'(0));
      div_sh_c   = {work_q[RW-1:W], work_q[W-1]};
      div_diff_c = div_sh_c - {1'b0, b_q};
      div_ge_c   = (div_sh_c >= {1'b0, b_q});
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      work_d   = work_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      neg_d    = neg_q;
      err_d    = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d   = op;
               a_d    = a;
               b_d    = b;
               work_d = (op == OP_MUL) ? {W'(0), b} : {W'(0), a};
               if (iter_op_c && (b != W'(0))) begin
                  state_d = ITER;
                  cnt_d   = CNT_W'(W);
                  busy_d  = 1'b1;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         ITER: begin
            if (op_q == OP_MUL) begin
               work_d = {mul_sum_c, work_q[W-1:1]};
            end else begin
               work_d = {(div_ge_c ? div_diff_c[W-1:0] : div_sh_c[W-1:0]), work_q[W-2:0], div_ge_c};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = FINISH;
               busy_d  = 1'b0;
            end
         end
         FINISH: begin
            state_d = IDLE;
            done_d  = 1'b1;
            neg_d   = 1'b0;
            err_d   = 1'b0;
            case (op_q)
               OP_ADD: result_d = RW'(a_q) + RW'(b_q);
               OP_SUB: begin
                  if (a_q >= b_q) begin
                     result_d = RW'(W'(a_q - b_q));
                  end else begin
                     result_d = RW'(W'(b_q - a_q));
                     neg_d    = 1'b1;
                  end
               end
               OP_MUL: result_d = work_q;
               OP_DIV: begin
                  result_d = (b_q == W'(0)) ? {RW{1'b1}} : {W'(0), work_q[W-1:0]};
                  err_d    = (b_q == W'(0));
               end
               OP_AND: result_d = RW'(a_q & b_q);
               OP_OR:  result_d = RW'(a_q | b_q);
               OP_XOR: result_d = RW'(a_q ^ b_q);
               OP_REM: begin
`ifdef CALC_REM_EN
                  result_d = (b_q == W'(0)) ? {RW{1'b1}} : {W'(0), work_q[RW-1:W]};
                  err_d    = (b_q == W'(0));
`else
                  result_d = RW'(0);
                  err_d    = 1'b1;
`endif
               end
               default: result_d = RW'(0);
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= CNT_W'(0);
         op_q     <= 3'b000;
         a_q      <= W'(0);
         b_q      <= W'(0);
         work_q   <= RW'(0);
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= RW'(0);
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         work_q   <= work_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         err_q    <= err_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign neg    = neg_q;
   assign err    = err_q;

endmodule

// File: doc/calc_seq_alu.md
Name: calc_seq_alu

Overview:
Parametrised successor to the 4-bit calculator datapath. Accepts two W-bit unsigned operands and a 3-bit opcode on a start strobe. Bitwise and add/sub ops complete in one cycle; multiply (shift-add) and divide (restoring) run iteratively over W cycles. A 2W-bit result is held with done/neg/err flags, and feeds the existing bin2bcd and display path in place of the combinational operation block.

Parameters:
W, 4, operand width in bits (W >= 2); result width is 2*W
CNT_W, $clog2(W)+1, iteration counter width (derived; do not override)

Ports:
clk     input   1     system clock, all logic on rising edge
rst     input   1     synchronous reset, active-high
start   input   1     request; accepted only when busy=0
op      input   3     opcode, sampled with start
a       input   W     operand A (unsigned), sampled with start
b       input   W     operand B (unsigned), sampled with start
busy    output  1     high while a multiply or divide is iterating
done    output  1     one-cycle pulse: result and flags updated this cycle
result  output  2*W   last result, held until the next done
neg     output  1     subtraction result was negative (result holds magnitude)
err     output  1     last operation was invalid (divide by zero, or unsupported opcode)

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, neg=0, err=0; counter and working registers cleared.
- Opcodes: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 rem (optional feature only).
- FSM states: IDLE, ITER, FINISH.
- IDLE:
  - start=1 latches a, b and op at edge k.
  - Single-cycle ops (000, 001, 100-110, div/rem with b=0, unsupported 111) -> FINISH.
  - mul or div with b!=0 -> ITER, counter=W, busy=1 from edge k.
- ITER:
  - Performs one shift-add (mul) or one shift-subtract (div) step per cycle and decrements the counter.
  - After the W-th step -> FINISH; busy drops at that same edge.
- FINISH:
  - Writes result/neg/err and pulses done for exactly one cycle, then returns to IDLE.
  - Single-cycle ops: done is high in cycle k+1.
  - mul/div: done is high in cycle k+W+1.
- Arithmetic:
  - add: zero-extended a+b (carry in bit W).
  - sub: if a>=b then result=a-b, neg=0; else result=b-a, neg=1.
  - mul: full 2W-bit product.
  - div: quotient in result[W-1:0], upper bits 0.
  - and/or/xor: zero-extended to 2W.
  - neg=0 and err=0 for all ops except as stated.
- div/rem with b=0: err=1, result = all ones, done in cycle k+1, no iteration.
- start while busy=1 or in FINISH is ignored; no queuing.
- start is level-sampled: if start stays high, a new op is accepted on the first IDLE cycle after FINISH.
- result/neg/err change only in FINISH (and on reset); they are stable otherwise.
- rst during ITER or FINISH aborts the op: no done pulse, all outputs return to reset values next cycle.

Optional Feature:
CALC_REM_EN:
- Defined: opcode 111 = remainder. Uses the same W-cycle restoring divider; remainder goes to result[W-1:0], upper bits 0; b=0 gives err=1, result all ones.
- Undefined: opcode 111 is unsupported and completes in one cycle with err=1, result=0. Divider remainder logic is omitted.

Test Plan:
1. W=4, rst high 2 cycles, then add a=9 b=7 -> done at k+1, result=8'd16, neg=0, err=0; busy never high.
2. sub a=3 b=5 -> result=8'd2, neg=1. Then sub a=5 b=5 -> result=0, neg=0.
3. mul a=15 b=15 -> busy high 4 cycles, done at k+5, result=8'd225. start pulsed again at k+2 with a=1 is ignored; result unaffected.
4. div a=13 b=4 -> done at k+5, result=8'd3. Then op=111 with the same operands:
   - with CALC_REM_EN: result=8'd1 at k+5.
   - without it: done at k+1, err=1, result=0.
5. div a=9 b=0 -> done at k+1, err=1, result=8'hFF, busy stays 0. Next add 1+1 clears err, result=2.
6. Start mul a=12 b=11, assert rst at k+2 -> no done pulse, busy=0, result=0 next cycle. Then mul 12*11 completes -> result=8'd132.
